// File: rtl/rast_pkg.sv
// Shared constants and FSM encoding for the rasterizer back end.
package rast_pkg;
  localparam int FRAC     = 6;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int WORD_W   = 16;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;
endpackage

// File: rtl/serial_word_rx.sv
// MSB-first 16-bit serial deserialiser; start_i captures bit 15 and (re)starts the count.
module serial_word_rx
  import rast_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] word_nxt_o,
  output logic              done_o
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  // word_nxt_o is the word including this cycle's bit, so it is complete while done_o is high
  assign word_nxt_o = {word_q[WORD_W-2:0], bit_i};
  assign done_o     = !start_i && (cnt_q == LAST_CNT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (start_i) begin
      word_q <= {{(WORD_W-1){1'b0}}, bit_i};
      cnt_q  <= CNT_W'(1);
    end else if (cnt_q != '0) begin
      word_q <= word_nxt_o;
      cnt_q  <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/pixel_writer.sv
// Deserialises rasterizer pixel words into single-cycle framebuffer writes, runs the
// framebuffer clear sequence and acknowledges triangle completion once writes have drained.
module pixel_writer #(
  parameter int FRAC     = rast_pkg::FRAC,
  parameter int SCREEN_W = rast_pkg::SCREEN_W,
  parameter int SCREEN_H = rast_pkg::SCREEN_H,
  parameter int AW       = 17
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WORD_START,
  input  logic          PX,
  input  logic          PY,
  input  logic          C,
  input  logic          PIX_VALID,
  input  logic          TRI_DONE,
  input  logic          CLEAR_REQ,
  input  logic [15:0]   BG_COLOR,
  output logic          FB_WE,
  output logic [AW-1:0] FB_ADDR,
  output logic [15:0]   FB_WDATA,
  output logic          BUSY,
  output logic          TRI_ACK,
  output logic [15:0]   DROP_CNT
);
  import rast_pkg::*;

  localparam logic [AW-1:0]            LAST_ADDR = AW'(SCREEN_W * SCREEN_H - 1);
  localparam logic signed [WORD_W-1:0] SW_S      = WORD_W'(SCREEN_W);
  localparam logic signed [WORD_W-1:0] SH_S      = WORD_W'(SCREEN_H);

  state_t            state_q, state_d;
  logic              vld_q;
  logic              pend_q;
  logic              fb_we_q;
  logic [AW-1:0]     fb_addr_q;
  logic [15:0]       fb_wdata_q;
  logic              busy_q;
  logic              ack_q;
  logic [15:0]       drop_q;

  logic              start_ok;
  logic              x_done, y_done, c_done, rx_unused;
  logic [WORD_W-1:0] x_word, y_word, c_word;
  logic signed [WORD_W-1:0] x_s, y_s;
  logic              on_screen;
  logic              vld_any;
  logic              pend_any;
  logic              drop_inc;
  logic [AW:0]       addr_w;

  // Words are only accepted where they can be received; during CLEAR they are discarded
  assign start_ok = WORD_START &&
                    ((state_q == RECV) || (state_q == WRITE) ||
                     ((state_q == IDLE) && !CLEAR_REQ));

  serial_word_rx u_rx_x (
    .CLK(CLK), .RST(RST), .start_i(start_ok), .bit_i(PX),
    .word_nxt_o(x_word), .done_o(x_done)
  );
  serial_word_rx u_rx_y (
    .CLK(CLK), .RST(RST), .start_i(start_ok), .bit_i(PY),
    .word_nxt_o(y_word), .done_o(y_done)
  );
  serial_word_rx u_rx_c (
    .CLK(CLK), .RST(RST), .start_i(start_ok), .bit_i(C),
    .word_nxt_o(c_word), .done_o(c_done)
  );

  // The three receivers run in lockstep, so only the x counter steers the FSM
  assign rx_unused = y_done ^ c_done;

  always_comb begin
    x_s       = $signed(x_word) >>> FRAC;
    y_s       = $signed(y_word) >>> FRAC;
    on_screen = !x_s[WORD_W-1] && (x_s < SW_S) && !y_s[WORD_W-1] && (y_s < SH_S);
    addr_w    = (AW+1)'(y_s) * (AW+1)'(SCREEN_W) + (AW+1)'(x_s);
    vld_any   = vld_q | PIX_VALID;
    pend_any  = pend_q | TRI_DONE;
  end

  always_comb begin
    state_d  = state_q;
    drop_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (CLEAR_REQ) begin
          state_d  = CLEAR;
          drop_inc = WORD_START;
        end else if (WORD_START) begin
          state_d = RECV;
        end
      end
      RECV: begin
        if (WORD_START) begin
          drop_inc = 1'b1;
        end else if (x_done) begin
          state_d  = WRITE;
          drop_inc = vld_any && !on_screen;
        end
      end
      WRITE: state_d = WORD_START ? RECV : IDLE;
      CLEAR: begin
        drop_inc = WORD_START;
        if (fb_addr_q == LAST_ADDR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: the write is decided on the edge that captures bit 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      vld_q      <= 1'b0;
      pend_q     <= 1'b0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ack_q   <= (state_d == IDLE) && pend_any;
      pend_q  <= pend_any && (state_d != IDLE);
      fb_we_q <= 1'b0;
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (CLEAR_REQ) begin
            fb_we_q    <= 1'b1;
            fb_addr_q  <= '0;
            fb_wdata_q <= BG_COLOR;
          end else if (WORD_START) begin
            vld_q <= PIX_VALID;
          end
        end
        RECV: begin
          if (WORD_START) begin
            vld_q <= PIX_VALID;
          end else if (x_done) begin
            vld_q <= 1'b0;
            if (vld_any && on_screen) begin
              fb_we_q    <= 1'b1;
              fb_addr_q  <= addr_w[AW-1:0];
              fb_wdata_q <= c_word;
            end
          end else begin
            vld_q <= vld_any;
          end
        end
        WRITE: begin
          if (WORD_START) vld_q <= PIX_VALID;
        end
        CLEAR: begin
          if (fb_addr_q != LAST_ADDR) begin
            fb_we_q   <= 1'b1;
            fb_addr_q <= fb_addr_q + 1'b1;
          end
        end
        default: vld_q <= 1'b0;
      endcase
    end
  end

  assign FB_WE    = fb_we_q;
  assign FB_ADDR  = fb_addr_q;
  assign FB_WDATA = fb_wdata_q;
  assign BUSY     = busy_q;
  assign TRI_ACK  = ack_q;
  assign DROP_CNT = drop_q;
endmodule

// File: tb/tb_pixel_writer.sv
// Directed, table-driven bench for pixel_writer with hand-sequenced multi-cycle cases.
module tb_pixel_writer;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        WORD_START = 1'b0, PX = 1'b0, PY = 1'b0, C = 1'b0;
  logic        PIX_VALID = 1'b0, TRI_DONE = 1'b0, CLEAR_REQ = 1'b0;
  logic [15:0] BG_COLOR = 16'h0;
  logic        FB_WE, BUSY, TRI_ACK;
  logic [16:0] FB_ADDR;
  logic [15:0] FB_WDATA, DROP_CNT;

  pixel_writer dut (
    .CLK(CLK), .RST(RST), .WORD_START(WORD_START), .PX(PX), .PY(PY), .C(C),
    .PIX_VALID(PIX_VALID), .TRI_DONE(TRI_DONE), .CLEAR_REQ(CLEAR_REQ), .BG_COLOR(BG_COLOR),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_WDATA(FB_WDATA), .BUSY(BUSY),
    .TRI_ACK(TRI_ACK), .DROP_CNT(DROP_CNT)
  );

  initial forever #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b1;
  int wc[$];
  int wa[$];
  int wd[$];
  int ac[$];

  always @(negedge CLK) begin
    if (mon_en && FB_WE === 1'b1) begin
      wc.push_back(cyc);
      wa.push_back(int'(FB_ADDR));
      wd.push_back(int'(FB_WDATA));
    end
    if (TRI_ACK === 1'b1) ac.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      WORD_START = 1'b0; PX = 1'b0; PY = 1'b0; C = 1'b0;
      PIX_VALID = 1'b0; TRI_DONE = 1'b0; CLEAR_REQ = 1'b0;
    end
  endtask

  task automatic drive_word(input logic [15:0] px, input logic [15:0] py, input logic [15:0] c,
                            input int vbit, input int nbits, input bit tdone, output int s);
    s = 0;
    for (int b = 0; b < nbits; b++) begin
      @(negedge CLK);
      if (b == 0) s = cyc;
      WORD_START = (b == 0);
      PX = px[15-b]; PY = py[15-b]; C = c[15-b];
      PIX_VALID = ((15 - b) == vbit);
      TRI_DONE = tdone && (b == 0);
    end
  endtask

  typedef struct {
    logic [15:0] px, py, c;
    int          vbit;
    bit          exp_we;
    int          exp_addr;
    int          drop_delta;
  } vec_t;

  vec_t vecs[9];
  int   exp_drop = 0;
  int   s, s2, t, clr_err;

  initial begin
    vecs[0] = '{16'h0140, 16'h0080, 16'hF800, 3,  1'b1, 645,   0};
    vecs[1] = '{16'h0140, 16'h0080, 16'hF800, -1, 1'b0, 0,     0};
    vecs[2] = '{16'hFFC0, 16'h0080, 16'hF800, 0,  1'b0, 0,     1};
    vecs[3] = '{16'h5000, 16'h0080, 16'hF800, 9,  1'b0, 0,     1};
    vecs[4] = '{16'h0000, 16'h0000, 16'h1234, 15, 1'b1, 0,     0};
    vecs[5] = '{16'h4FC0, 16'h3BC0, 16'hABCD, 0,  1'b1, 76799, 0};
    vecs[6] = '{16'h0000, 16'h3C00, 16'h5555, 4,  1'b0, 0,     1};
    vecs[7] = '{16'h017F, 16'h00BF, 16'h0F0F, 8,  1'b1, 645,   0};
    vecs[8] = '{16'h0040, 16'h8000, 16'h7777, 1,  1'b0, 0,     1};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset_fb_we", FB_WE, 0);
    chk("reset_fb_addr", FB_ADDR, 0);
    chk("reset_fb_wdata", FB_WDATA, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_tri_ack", TRI_ACK, 0);
    chk("reset_drop_cnt", DROP_CNT, 0);

    for (int v = 0; v < 9; v++) begin
      wc.delete(); wa.delete(); wd.delete();
      drive_word(vecs[v].px, vecs[v].py, vecs[v].c, vecs[v].vbit, 16, 1'b0, s);
      idle(3);
      chk($sformatf("vec%0d_write_count", v), wc.size(), vecs[v].exp_we ? 1 : 0);
      if (vecs[v].exp_we && wc.size() == 1) begin
        chk($sformatf("vec%0d_latency", v), wc[0] - s, 16);
        chk($sformatf("vec%0d_addr", v), wa[0], vecs[v].exp_addr);
        chk($sformatf("vec%0d_data", v), wd[0], int'(vecs[v].c));
      end
      exp_drop += vecs[v].drop_delta;
      chk($sformatf("vec%0d_drop_cnt", v), DROP_CNT, exp_drop);
    end

    // back-to-back: second WORD_START lands on the first word's WRITE cycle
    wc.delete(); wa.delete(); wd.delete();
    drive_word(16'h0140, 16'h0080, 16'hF800, 3, 16, 1'b0, s);
    drive_word(16'h0280, 16'h0040, 16'h07E0, 0, 16, 1'b0, s2);
    idle(3);
    chk("b2b_write_count", wc.size(), 2);
    chk("b2b_second_start", s2 - s, 16);
    if (wc.size() == 2) begin
      chk("b2b_first_latency", wc[0] - s, 16);
      chk("b2b_spacing", wc[1] - wc[0], 16);
      chk("b2b_addr0", wa[0], 645);
      chk("b2b_addr1", wa[1], 330);
      chk("b2b_data1", wd[1], 32'h07E0);
    end
    chk("b2b_drop_cnt", DROP_CNT, exp_drop);

    // restart: new WORD_START on the cycle carrying bit 7 aborts the first word
    wc.delete(); wa.delete(); wd.delete();
    drive_word(16'h0140, 16'h0080, 16'hF800, 15, 8, 1'b0, s);
    drive_word(16'h01C0, 16'h00C0, 16'h1234, 5, 16, 1'b0, s2);
    idle(3);
    exp_drop += 1;
    chk("restart_write_count", wc.size(), 1);
    if (wc.size() == 1) begin
      chk("restart_latency", wc[0] - s2, 16);
      chk("restart_addr", wa[0], 967);
      chk("restart_data", wd[0], 32'h1234);
    end
    chk("restart_drop_cnt", DROP_CNT, exp_drop);

    // TRI_DONE with WORD_START: ack one cycle after the WRITE cycle
    wc.delete(); wa.delete(); wd.delete(); ac.delete();
    drive_word(16'h0040, 16'h0000, 16'hCAFE, 2, 16, 1'b1, s);
    chk("tri_busy_in_recv", BUSY, 1);
    idle(4);
    chk("tri_write_count", wc.size(), 1);
    chk("tri_ack_count", ac.size(), 1);
    if (wc.size() == 1) chk("tri_write_cycle", wc[0] - s, 16);
    if (ac.size() == 1) chk("tri_ack_cycle", ac[0] - s, 17);

    // TRI_DONE while idle: ack on the next cycle
    ac.delete();
    @(negedge CLK);
    t = cyc;
    TRI_DONE = 1'b1;
    idle(3);
    chk("tri_idle_ack_count", ac.size(), 1);
    if (ac.size() == 1) chk("tri_idle_ack_cycle", ac[0] - t, 1);

    // full clear, with one WORD_START ignored mid-sequence
    mon_en = 1'b0;
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    BG_COLOR = 16'h001F;
    clr_err = 0;
    for (int i = 0; i < 76800; i++) begin
      @(negedge CLK);
      CLEAR_REQ = 1'b0;
      BG_COLOR = 16'h0;
      WORD_START = (i == 10);
      if (FB_WE !== 1'b1 || FB_ADDR !== 17'(i) || FB_WDATA !== 16'h001F) clr_err++;
    end
    exp_drop += 1;
    chk("clear_bad_writes", clr_err, 0);
    @(negedge CLK);
    WORD_START = 1'b0;
    chk("clear_done_we", FB_WE, 0);
    chk("clear_done_busy", BUSY, 0);
    chk("clear_drop_cnt", DROP_CNT, exp_drop);

    // clear interrupted by async reset at address 1000
    @(negedge CLK);
    CLEAR_REQ = 1'b1;
    BG_COLOR = 16'h001F;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge CLK);
      CLEAR_REQ = 1'b0;
    end
    chk("clear2_addr_before_rst", FB_ADDR, 1000);
    chk("clear2_we_before_rst", FB_WE, 1);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_clear_we", FB_WE, 0);
    chk("rst_mid_clear_busy", BUSY, 0);
    chk("rst_mid_clear_drop", DROP_CNT, 0);
    @(negedge CLK);
    RST = 1'b0;
    idle(2);
    chk("post_rst_we", FB_WE, 0);
    chk("post_rst_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
